// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side, memory-side and cache-write signals of the I-cache refill controller.
interface icache_refill_ctrl_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
);
  localparam int unsigned LINE_W = LINE_WORDS * DATA_W;

  logic              ifetch_valid;
  logic              icache_hit;
  logic [ADDR_W-1:0] ipc;
  logic              omem_req;
  logic [ADDR_W-1:0] omem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [LINE_W-1:0] oline;
  logic [ADDR_W-1:0] oline_addr;
  logic              oline_we;
  logic              ostall;

  // Controller side.
  modport master (
    input  ifetch_valid, icache_hit, ipc, imem_ack, imem_rdata,
    output omem_req, omem_addr, oline, oline_addr, oline_we, ostall
  );

  // Fetch stage / memory / cache side.
  modport slave (
    output ifetch_valid, icache_hit, ipc, imem_ack, imem_rdata,
    input  omem_req, omem_addr, oline, oline_addr, oline_we, ostall
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: fetches a line word by word over req/ack and writes it to the cache.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input logic                clk,
  input logic                rstn,
  icache_refill_ctrl_if.master bus
);
  localparam int unsigned LINE_W     = LINE_WORDS * DATA_W;
  localparam int unsigned CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned WORD_BYTES = DATA_W / 8;
  localparam int unsigned LINE_BYTES = LINE_WORDS * WORD_BYTES;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] oline_q;
  logic [ADDR_W-1:0] oline_addr_q;
  logic              start, take, last;

  // State register; reset abandons any refill in progress.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state plus the capture/launch strobes for the datapath.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    take    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ifetch_valid && !bus.icache_hit) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          take = 1'b1;
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            last    = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line buffer with the incoming word merged into its slot.
  always_comb begin
    line_d = line_q;
    line_d[cnt_q * DATA_W +: DATA_W] = bus.imem_rdata;
  end

  // Refill datapath: base address, word counter, line buffer and the cache write image.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt_q        <= '0;
      base_q       <= '0;
      line_q       <= '0;
      oline_q      <= '0;
      oline_addr_q <= '0;
    end else begin
      if (start) begin
        base_q <= bus.ipc & ~ADDR_W'(LINE_BYTES - 1);
        cnt_q  <= '0;
      end else if (take) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (take) line_q <= line_d;
      if (last) begin
        oline_q      <= line_d;
        oline_addr_q <= base_q;
      end
    end
  end

  assign bus.omem_req   = (state_q == REQ);
  assign bus.omem_addr  = base_q + (ADDR_W'(cnt_q) * ADDR_W'(WORD_BYTES));
  assign bus.oline_we   = (state_q == FILL);
  assign bus.oline      = oline_q;
  assign bus.oline_addr = oline_addr_q;
  // Stall follows a miss in the same cycle, and stays up for the whole refill.
  assign bus.ostall     = !rstn &&
                          ((state_q != IDLE) || (bus.ifetch_valid && !bus.icache_hit));
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with a randomized memory responder.
module tb_icache_refill_ctrl;
  logic clk;
  logic rstn;

  icache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) bus ();

  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  bit spurious_en = 0;

  logic [31:0]  exp_addr_q[$];
  logic [127:0] exp_line_q[$];
  logic [31:0]  exp_base_q[$];
  logic [31:0]  mem_data_q[$];
  int           mem_wait_q[$];
  logic [127:0] last_line = '0;
  logic [31:0]  last_base = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: honours the per-word wait chosen at issue time, returns the queued data.
  initial begin
    int wait_left;
    wait_left = -1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.omem_req) begin
        if (wait_left < 0) wait_left = (mem_wait_q.size() != 0) ? mem_wait_q.pop_front() : 0;
        if (wait_left == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : $urandom;
          wait_left      = -1;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        wait_left      = -1;
        bus.imem_ack   = spurious_en && ($urandom_range(0, 3) == 0);
        bus.imem_rdata = $urandom;
      end
    end
  end

  // Monitor: compares every DUT-presented event against the scoreboard queues.
  initial begin
    bit           prev_wait, prev_we, exp_stall;
    logic [31:0]  prev_addr, ea, eb;
    logic [127:0] el;
    prev_wait = 0;
    prev_we   = 0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        chk("rst_req", bus.omem_req, 0);
        chk("rst_we", bus.oline_we, 0);
        chk("rst_stall", bus.ostall, 0);
        chk("rst_addr", bus.omem_addr, 0);
        chk("rst_line", bus.oline, 0);
        chk("rst_line_addr", bus.oline_addr, 0);
        prev_wait = 0;
        prev_we   = 0;
      end else begin
        exp_stall = (exp_line_q.size() != 0) || (bus.ifetch_valid && !bus.icache_hit);
        chk("stall", bus.ostall, exp_stall);
        if (prev_wait && bus.omem_req) chk("addr_hold", bus.omem_addr, prev_addr);
        if (bus.omem_req && exp_addr_q.size() == 0) chk("unexpected_req", bus.omem_req, 0);
        if (bus.omem_req && bus.imem_ack && exp_addr_q.size() != 0) begin
          ea = exp_addr_q.pop_front();
          chk("req_addr", bus.omem_addr, ea);
          hs_count++;
        end
        if (bus.oline_we) begin
          chk("we_pulse_width", prev_we, 0);
          if (exp_line_q.size() == 0) begin
            chk("unexpected_we", bus.oline_we, 0);
          end else begin
            el = exp_line_q.pop_front();
            eb = exp_base_q.pop_front();
            chk("all_words_acked", exp_addr_q.size(), 0);
            chk("line", bus.oline, el);
            chk("line_addr", bus.oline_addr, eb);
            last_line = el;
            last_base = eb;
          end
        end else begin
          chk("line_hold", bus.oline, last_line);
          chk("line_addr_hold", bus.oline_addr, last_base);
        end
        prev_wait = bus.omem_req && !bus.imem_ack;
        prev_addr = bus.omem_addr;
        prev_we   = bus.oline_we;
      end
    end
  end

  // Reference model: a miss yields four word reads from the aligned base, then one line write.
  task automatic issue(input logic [31:0] pc, input bit directed, input int wlo, input int whi,
                       output int exp_stall);
    logic [31:0]  base, w;
    logic [127:0] line;
    int           wt;
    base      = pc & ~32'hF;
    line      = '0;
    exp_stall = 2;
    for (int k = 0; k < 4; k++) begin
      w  = directed ? (32'hA0 + 32'(k)) : $urandom;
      wt = $urandom_range(whi, wlo);
      line[32*k +: 32] = w;
      exp_addr_q.push_back(base + 32'(4 * k));
      mem_data_q.push_back(w);
      mem_wait_q.push_back(wt);
      exp_stall += wt + 1;
    end
    exp_line_q.push_back(line);
    exp_base_q.push_back(base);
    bus.ifetch_valid = 1'b1;
    bus.icache_hit   = 1'b0;
    bus.ipc          = pc;
  endtask

  // One full refill; called at a negedge, returns at the negedge after the write cycle.
  task automatic run_miss(input logic [31:0] pc, input bit directed, input int wlo, input int whi,
                          input bit refetch, input bit redirect_en, input logic [31:0] redirect_pc);
    int exp_stall, stall_cycles;
    bit done;
    issue(pc, directed, wlo, whi, exp_stall);
    stall_cycles = 0;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (bus.ostall) stall_cycles++;
      if (bus.oline_we) done = 1;
      @(negedge clk);
      if (done) begin
        if (refetch) begin
          bus.ifetch_valid = 1'b1;
          bus.icache_hit   = 1'b1;
          bus.ipc          = pc;
        end
      end else if (redirect_en) begin
        bus.ifetch_valid = 1'b1;
        bus.icache_hit   = 1'b0;
        bus.ipc          = redirect_pc;
      end else begin
        bus.ifetch_valid = 1'($urandom);
        bus.icache_hit   = 1'($urandom);
        bus.ipc          = $urandom;
      end
    end
    chk("refill_done", done, 1);
    chk("stall_cycles", stall_cycles, exp_stall);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ifetch_valid = 1'($urandom);
      bus.icache_hit   = 1'b1;
      bus.ipc          = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic flush_model();
    exp_addr_q.delete();
    exp_line_q.delete();
    exp_base_q.delete();
    mem_data_q.delete();
    mem_wait_q.delete();
    last_line = '0;
    last_base = '0;
  endtask

  initial begin
    int start_hs;
    bit chain;
    logic [31:0] pc;
    rstn = 1'b1;
    bus.ifetch_valid = 1'b0;
    bus.icache_hit   = 1'b0;
    bus.ipc          = '0;

    // Reset with random fetch-side inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ifetch_valid = 1'($urandom);
      bus.icache_hit   = 1'($urandom);
      bus.ipc          = $urandom;
    end
    @(negedge clk);
    rstn = 1'b0;
    bus.ifetch_valid = 1'b1;
    bus.icache_hit   = 1'b1;
    repeat (3) @(negedge clk);

    // Zero-wait miss with known data.
    run_miss(32'h0000_1234, 1, 0, 0, 1, 0, '0);
    idle(2);

    // Three wait states per word, with spurious acks outside the request phase.
    spurious_en = 1;
    run_miss(32'h0000_5678, 0, 3, 3, 1, 0, '0);
    idle(4);

    // Top-of-address-space line.
    run_miss(32'hFFFF_FFF8, 0, 0, 2, 1, 0, '0);
    idle(2);

    // Reset after the second word, then the same miss restarts from word 0.
    spurious_en = 0;
    begin
      int dummy;
      start_hs = hs_count;
      issue(32'h0000_2468, 0, 0, 0, dummy);
      for (int c = 0; c < 50 && hs_count < start_hs + 2; c++) @(negedge clk);
      chk("two_acks_before_reset", hs_count - start_hs, 2);
      rstn = 1'b1;
      flush_model();
      #1;
      chk("abort_req", bus.omem_req, 0);
      chk("abort_we", bus.oline_we, 0);
      @(negedge clk);
      bus.ifetch_valid = 1'($urandom);
      bus.icache_hit   = 1'($urandom);
      @(negedge clk);
      rstn = 1'b0;
      bus.ifetch_valid = 1'b1;
      bus.icache_hit   = 1'b1;
      @(negedge clk);
      run_miss(32'h0000_2468, 0, 0, 1, 1, 0, '0);
      idle(2);
    end

    // Redirect to 0x4000 during the refill; the miss there chains right after the write.
    run_miss(32'h0000_8000, 0, 0, 2, 0, 1, 32'h0000_4000);
    run_miss(32'h0000_4000, 0, 0, 1, 1, 0, '0);
    idle(2);

    // Randomized traffic: random PCs, waits, chained misses and spurious acks.
    spurious_en = 1;
    chain = 0;
    for (int n = 0; n < 20; n++) begin
      pc = $urandom;
      if ($urandom_range(0, 4) == 0) pc = 32'hFFFF_FFF0 | (32'($urandom) & 32'hF);
      chain = (n != 19) && ($urandom_range(0, 2) == 0);
      run_miss(pc, 0, 0, $urandom_range(0, 4), !chain, $urandom_range(0, 1) == 1, $urandom);
      if (!chain) idle($urandom_range(1, 3));
    end
    spurious_en = 0;
    idle(3);

    chk("queues_drained", exp_addr_q.size() + exp_line_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss handler that sits directly upstream of the instruction cache in the fetch stage. On a fetch miss it stalls the PC and reads the four 32-bit words of the missing line from main memory over a req/ack bus. It assembles them into a 128-bit line, writes that line into the cache with a one-cycle strobe, then releases the stall so the refetch hits.

Parameters:
ADDR_W, 32, byte-address width of PC and memory bus
DATA_W, 32, memory bus word width
LINE_WORDS, 4, words per cache line; line width = LINE_WORDS*DATA_W = 128

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  reset, asynchronous, active-high (1 = reset asserted)
ifetch_valid  input  1  fetch stage is requesting an instruction this cycle
icache_hit  input  1  cache hit status for ipc, from the instruction cache
ipc  input  ADDR_W  current PC presented to the cache
omem_req  output  1  memory read request, held until acknowledged
omem_addr  output  ADDR_W  word address being requested
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  DATA_W  read data, valid only when imem_ack=1
oline  output  128  assembled line to cache (word k at bits [32k+31:32k])
oline_addr  output  ADDR_W  line-aligned base address for cache tag/index write
oline_we  output  1  one-cycle cache write strobe
ostall  output  1  1 = hold PC (drives the fetch stage's PC-update enable low)

Behaviour:
- States: IDLE, REQ, FILL.
- Reset (async, rstn=1): state=IDLE, word counter=0, base=0, line buffer=0. All outputs are 0, including ostall.
- IDLE:
  - omem_req=0, oline_we=0.
  - ostall = ifetch_valid & ~icache_hit (combinational, same cycle as the miss).
  - On ifetch_valid & ~icache_hit: base <= {ipc[ADDR_W-1:4],4'b0}, counter <= 0, go to REQ.
- REQ:
  - omem_req=1, omem_addr = base + 4*counter, computed mod 2^ADDR_W (wraps at the top of address space). ostall=1.
  - On imem_ack: word[counter] <= imem_rdata, counter++.
  - If counter was LINE_WORDS-1, go to FILL (omem_req drops the following cycle). Otherwise stay in REQ with req still high; back-to-back acks are legal.
  - No ack: hold omem_req and omem_addr stable indefinitely; there is no timeout.
- FILL:
  - oline_we=1 for exactly one cycle. oline=assembled line, oline_addr=base, ostall=1.
  - Go to IDLE. In IDLE the cache lookup repeats and normally hits, so ostall falls.
- oline and oline_addr hold their last values outside FILL; only oline_we qualifies them.
- imem_ack outside REQ is ignored; no state or data changes.
- ipc, ifetch_valid and icache_hit are ignored outside IDLE. A PC change or branch redirect mid-refill does not abort the refill; the line is still written.
- Miss again in IDLE right after FILL (e.g. redirected PC): a new refill starts immediately.
- Reset mid-refill: abort at once, discard the partial line, no oline_we pulse, omem_req=0 asynchronously.
- Minimum miss penalty with zero-wait memory:
  - miss in cycle 0; REQ in cycles 1-4 with an ack each cycle; FILL in cycle 5; IDLE/hit in cycle 6.
  - ostall is high in cycles 0-5.

Test Plan:
- Reset: hold rstn=1 with random inputs -> omem_req, oline_we, ostall all 0. Release, ifetch_valid=1, icache_hit=1 -> ostall stays 0, no requests.
- Zero-wait miss: ipc=0x0000_1234, hit=0, ack every cycle with data 0xA0,0xA1,0xA2,0xA3 -> addresses 0x1230,0x1234,0x1238,0x123C. Then oline_we for exactly 1 cycle, oline=0x000000A3_000000A2_000000A1_000000A0, oline_addr=0x1230, ostall high for 6 cycles.
- Wait states: ack delayed 3 cycles per word -> omem_req and omem_addr stable while waiting. Each word is captured exactly once, 4 acks total; spurious ack in IDLE after fill changes nothing.
- Address wrap: ipc=0xFFFF_FFF8 miss -> base 0xFFFF_FFF0, last request 0xFFFF_FFFC, oline_addr=0xFFFF_FFF0.
- Reset mid-refill: assert rstn after second ack -> omem_req drops immediately, no oline_we. After release plus a new miss, the refill restarts at word 0.
- Redirect during refill: change ipc to 0x4000 during REQ -> refill completes for the original line. Next IDLE cycle with hit=0 at 0x4000 starts a new refill at 0x4000.
